reg_write_arbiter: RTL

//   Shares the single register-file write port (RegWrite/AW/WriteData) between
//   two writeback requesters: A = ALU result, B = memory-load result. Each

---
 rtl/reg_write_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - two-requester buffered register-file write arbiter with pending-write query
module reg_write_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter bit DROP_ZERO  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] AW,
    output logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] q_addr1,
    input  logic [ADDR_W-1:0] q_addr2,
    output logic              q_hit1,
    output logic              q_hit2,
    output logic              idle
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    // Index 0 is requester A (ALU), index 1 is requester B (load).
    logic [ADDR_W-1:0] addr_q [2][FIFO_DEPTH];
    logic [ADDR_W-1:0] addr_d [2][FIFO_DEPTH];
    logic [DATA_W-1:0] data_q [2][FIFO_DEPTH];
    logic [DATA_W-1:0] data_d [2][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [2];
    logic [PTR_W-1:0]  wr_ptr_d [2];
    logic [PTR_W-1:0]  rd_ptr_q [2];
    logic [PTR_W-1:0]  rd_ptr_d [2];
    logic [CNT_W-1:0]  count_q [2];
    logic [CNT_W-1:0]  count_d [2];
    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] aw_q, aw_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              last_grant_b_q, last_grant_b_d;

    logic              entry_vld [2][FIFO_DEPTH];
    logic [ADDR_W-1:0] in_addr [2];
    logic [DATA_W-1:0] in_data [2];
    logic [PTR_W-1:0]  ofs;
    logic              a_in_b, b_in_a, a_rdy, b_rdy, hit1, hit2;
    logic [1:0]        push, grant, nonempty;

    // Occupancy, WAW blocking, ready, arbitration and pending-write query.
    always_comb begin
        in_addr[0] = a_addr;
        in_addr[1] = b_addr;
        in_data[0] = a_data;
        in_data[1] = b_data;
        ofs        = '0;
        a_in_b     = 1'b0;
        b_in_a     = 1'b0;
        hit1       = 1'b0;
        hit2       = 1'b0;
        for (int r = 0; r < 2; r++) begin
            nonempty[r] = (count_q[r] != '0);
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                // An entry is live when its distance from the head is below the count.
                ofs             = PTR_W'(i) - rd_ptr_q[r];
                entry_vld[r][i] = ({1'b0, ofs} < count_q[r]);
                if (entry_vld[r][i]) begin
                    if (r == 1 && addr_q[r][i] == a_addr) a_in_b = 1'b1;
                    if (r == 0 && addr_q[r][i] == b_addr) b_in_a = 1'b1;
                    if (addr_q[r][i] == q_addr1) hit1 = 1'b1;
                    if (addr_q[r][i] == q_addr2) hit2 = 1'b1;
                end
            end
        end
        if (reg_write_q && aw_q == q_addr1) hit1 = 1'b1;
        if (reg_write_q && aw_q == q_addr2) hit2 = 1'b1;
        if (DROP_ZERO && q_addr1 == '0) hit1 = 1'b0;
        if (DROP_ZERO && q_addr2 == '0) hit2 = 1'b0;
        q_hit1 = rst_n && hit1;
        q_hit2 = rst_n && hit2;

        // A wins a same-cycle tie on the same address; B waits for it to drain.
        a_rdy = rst_n && (count_q[0] != FULL_CNT) && !a_in_b;
        b_rdy = rst_n && (count_q[1] != FULL_CNT) && !b_in_a
                && !(a_valid && a_rdy && a_addr == b_addr);
        a_ready = a_rdy;
        b_ready = b_rdy;
        push[0] = a_valid && a_rdy && !(DROP_ZERO && a_addr == '0);
        push[1] = b_valid && b_rdy && !(DROP_ZERO && b_addr == '0);

        grant[0] = nonempty[0] && (!nonempty[1] || last_grant_b_q);
        grant[1] = nonempty[1] && !grant[0];

        idle = !nonempty[0] && !nonempty[1] && !reg_write_q;
    end

    // FIFO pointer/storage updates and registered write-port outputs.
    always_comb begin
        addr_d         = addr_q;
        data_d         = data_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        last_grant_b_d = last_grant_b_q;
        reg_write_d    = grant[0] || grant[1];
        aw_d           = aw_q;
        wd_d           = wd_q;
        for (int r = 0; r < 2; r++) begin
            if (push[r]) begin
                addr_d[r][wr_ptr_q[r]] = in_addr[r];
                data_d[r][wr_ptr_q[r]] = in_data[r];
                wr_ptr_d[r]            = wr_ptr_q[r] + PTR_W'(1);
            end
            if (grant[r]) begin
                rd_ptr_d[r] = rd_ptr_q[r] + PTR_W'(1);
            end
            count_d[r] = count_q[r] + CNT_W'(push[r]) - CNT_W'(grant[r]);
        end
        if (grant[0]) begin
            aw_d           = addr_q[0][rd_ptr_q[0]];
            wd_d           = data_q[0][rd_ptr_q[0]];
            last_grant_b_d = 1'b0;
        end else if (grant[1]) begin
            aw_d           = addr_q[1][rd_ptr_q[1]];
            wd_d           = data_q[1][rd_ptr_q[1]];
            last_grant_b_d = 1'b1;
        end
    end

    // Control state with synchronous reset; last grant starts at B so A wins first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < 2; r++) begin
                wr_ptr_q[r] <= '0;
                rd_ptr_q[r] <= '0;
                count_q[r]  <= '0;
            end
            reg_write_q    <= 1'b0;
            aw_q           <= '0;
            wd_q           <= '0;
            last_grant_b_q <= 1'b1;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            reg_write_q    <= reg_write_d;
            aw_q           <= aw_d;
            wd_q           <= wd_d;
            last_grant_b_q <= last_grant_b_d;
        end
    end

    // Entry storage needs no reset: emptied pointers make stale contents invisible.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign RegWrite  = reg_write_q;
    assign AW        = aw_q;
    assign WriteData = wd_q;

endmodule
